// File: rtl/serial_add_sub_if.sv
// Handshake and operand bundle for the bit-serial adder/subtractor.
//
// Handshake: the requester raises start with op/a/b valid; the request is
// taken on the rising edge where busy=0 (IDLE or DONE) and ignored otherwise.
// busy is high while the operation runs; done pulses for exactly one cycle
// with result/flag valid. busy and done are never high together.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag;

    modport master (
        output start, op, a, b,
        input  busy, done, result, flag
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, flag
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
// LSB first, WIDTH clocks per operation. Subtraction is a + ~b + 1, so the
// borrow flag is the inverted final carry.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_sub_if.slave      bus,
    output logic [1:0]           state_dbg
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             op_q;
    logic             flag_q;
    logic [CW-1:0]    count_q;

    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;
    logic             accept;
    logic [WIDTH:0]   res_shift;

    // Full-adder cell on the current LSBs and the control decode.
    always_comb begin
        sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_bit   = (count_q == CW'(WIDTH - 1));
        res_shift  = {sum_bit, res_q};
        accept     = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start in DONE goes straight back to RUN.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN:   if (last_bit)  state_next = S_DONE;
            S_DONE:  state_next = bus.start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand load, serial shift and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            flag_q  <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.op ? ~bus.b : bus.b;
            carry_q <= bus.op;
            op_q    <= bus.op;
            count_q <= '0;
        end else if (state == S_RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= carry_next;
            res_q   <= res_shift[WIDTH:1];
            count_q <= count_q + CW'(1);
            if (last_bit) begin
                flag_q <= op_q ? ~carry_next : carry_next;
            end
        end
    end

    assign bus.busy   = (state == S_RUN);
    assign bus.done   = (state == S_DONE);
    assign bus.result = res_q;
    assign bus.flag   = flag_q;
    assign state_dbg  = state;
endmodule
